// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, one transaction at a time.
// Build option MEM_ARB_RR_EN selects round-robin arbitration instead of data priority with a starvation limit.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                instruction_valid,
   input  logic [ADDR_W-1:0]   instruction_addr,
   output logic                instruction_ack,
   output logic                instruction_ready,
   output logic [DATA_W-1:0]   instruction_read,
   input  logic                data_read_valid,
   input  logic                data_write_valid,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_write,
   input  logic [DATA_W/8-1:0] data_write_byte,
   output logic                data_ack,
   output logic                data_ready,
   output logic [DATA_W-1:0]   data_read,
   output logic                mem_valid,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ack,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   // FSM state for observation: 0 = IDLE, 1 = ISSUE, 2 = WAIT
   output logic [1:0]          dbg_state
);

   // Handshake: a requester holds valid until its ack; ack mirrors mem_ack while that
   // requester owns the ISSUE cycle, and ready mirrors mem_ready once the request was accepted.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;
   localparam int   STRB_W   = DATA_W / 8;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;

   logic inst_req;
   logic data_req;
   logic grant_data;
   logic granting;

   assign inst_req = instruction_valid;
   assign data_req = data_read_valid | data_write_valid;
   assign granting = (state_q == IDLE) && (inst_req || data_req);

`ifdef MEM_ARB_RR_EN
   logic rr_q, rr_d;

   always_comb begin
      grant_data = data_req && !(inst_req && (rr_q == OWN_INST));
      rr_d       = rr_q;
      if (granting) begin
         rr_d = grant_data ? OWN_INST : OWN_DATA;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q <= OWN_INST;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_q, starve_d;

   // A waiting fetch wins once it has been passed over LIMIT times in a row.
   always_comb begin
      grant_data = data_req && !(inst_req && (starve_q == LIMIT));
      starve_d   = starve_q;
      if (granting) begin
         if (grant_data && inst_req) begin
            starve_d = starve_q + 4'd1;
         end else begin
            starve_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         IDLE: begin
            if (granting) begin
               state_d = ISSUE;
               owner_d = grant_data ? OWN_DATA : OWN_INST;
               we_d    = grant_data && data_write_valid;
               addr_d  = grant_data ? data_addr : instruction_addr;
               wdata_d = (grant_data && data_write_valid) ? data_write : '0;
               wstrb_d = (grant_data && data_write_valid) ? data_write_byte : '0;
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               state_d = mem_ready ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (mem_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= OWN_INST;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   logic issue_ack;
   logic ready_window;

   assign issue_ack    = (state_q == ISSUE) && mem_ack;
   assign ready_window = issue_ack || (state_q == WAIT);

   assign mem_valid = (state_q == ISSUE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

   assign instruction_ack   = issue_ack && (owner_q == OWN_INST);
   assign data_ack          = issue_ack && (owner_q == OWN_DATA);
   assign instruction_ready = mem_ready && ready_window && (owner_q == OWN_INST);
   assign data_ready        = mem_ready && ready_window && (owner_q == OWN_DATA);
   assign instruction_read  = mem_rdata;
   assign data_read         = mem_rdata;

   assign dbg_state = state_q;

endmodule
